// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch / lap timer.
package stopwatch_pkg;

   typedef enum logic {
      CNT_UP   = 1'b0,
      CNT_DOWN = 1'b1
   } cnt_mode_e;

   localparam int DEFAULT_MAX      = 99;
   localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/stopwatch_lap_timer_if.sv
// Control / status bundle between the UI logic (master) and the timer (slave).
interface stopwatch_lap_timer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  clear;
   logic                  start;
   logic                  stop;
   logic                  mode_down;
   logic                  load;
   logic [DATA_WIDTH-1:0] load_value;
   logic                  lap;
   logic                  lap_rd;
   logic [DATA_WIDTH-1:0] count;
   logic                  running;
   logic                  wrap;
   logic [DATA_WIDTH-1:0] lap_data;
   logic                  lap_valid;
   logic                  lap_full;
   logic                  lap_ovf;

   modport master (
      output clear, start, stop, mode_down, load, load_value, lap, lap_rd,
      input  count, running, wrap, lap_data, lap_valid, lap_full, lap_ovf
   );

   modport slave (
      input  clear, start, stop, mode_down, load, load_value, lap, lap_rd,
      output count, running, wrap, lap_data, lap_valid, lap_full, lap_ovf
   );
endinterface

// File: rtl/lap_fifo.sv
// Show-ahead FIFO for captured lap values; push while full succeeds only
// when a pop frees a slot on the same edge.
module lap_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;
   logic             pop_ok, push_ok;

   // Pointer-derived status; the extra MSB separates full from empty.
   always_comb begin
      empty   = (wp == rp);
      full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      dout    = empty ? '0 : mem[rp[AW-1:0]];
   end

   // Storage and pointers; clear drops everything including a same-edge push.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push_ok) begin
            mem[wp[AW-1:0]] <= din;
            wp              <= wp + 1'b1;
         end
         if (pop_ok) rp <= rp + 1'b1;
      end
   end
endmodule

// File: rtl/stopwatch_lap_timer.sv
// Prescaled up/down stopwatch with preload, wrap pulse and lap-capture FIFO.
module stopwatch_lap_timer
   import stopwatch_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX        = DEFAULT_MAX,
   parameter int PRESCALE   = DEFAULT_PRESCALE,
   parameter int LAP_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   stopwatch_lap_timer_if.slave bus
);
   localparam int                    PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DATA_WIDTH-1:0] MAXV = DATA_WIDTH'(MAX);
   localparam logic [PW-1:0]         PTOP = PW'(PRESCALE - 1);

   logic [DATA_WIDTH-1:0] count_q;
   logic [PW-1:0]         presc, presc_cur;
   logic                  running_q, wrap_q, ovf_q;
   logic                  act, tick, load_ok;
   logic                  fifo_empty, fifo_full;
   cnt_mode_e             mode;

   // Run enable and step strobe; a stopped timer always restarts its phase at 0.
   always_comb begin
      mode      = cnt_mode_e'(bus.mode_down);
      act       = !bus.clear && !bus.stop && (running_q || bus.start);
      presc_cur = running_q ? presc : '0;
      tick      = act && (presc_cur == PTOP);
      load_ok   = bus.load && !running_q && !act;
   end

   // Counter, run flag, prescaler and wrap pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         presc     <= '0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         running_q <= act;
         wrap_q    <= 1'b0;
         presc     <= !act ? '0 : (tick ? '0 : presc_cur + 1'b1);
         if (bus.clear) begin
            count_q <= '0;
         end else if (load_ok) begin
            count_q <= (bus.load_value > MAXV) ? MAXV : bus.load_value;
         end else if (tick) begin
            if (mode == CNT_UP) begin
               if (count_q == MAXV) begin
                  count_q <= '0;
                  wrap_q  <= 1'b1;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end else begin
               if (count_q == '0) begin
                  count_q <= MAXV;
                  wrap_q  <= 1'b1;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
         end
      end
   end

   // Sticky overflow: a lap arrived with no room and no same-edge pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   ovf_q <= 1'b0;
      else if (bus.clear)                             ovf_q <= 1'b0;
      else if (bus.lap && fifo_full && !bus.lap_rd)   ovf_q <= 1'b1;
   end

   lap_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (LAP_DEPTH)
   ) u_lap_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (bus.clear),
      .push    (bus.lap),
      .pop     (bus.lap_rd),
      .din     (count_q),
      .dout    (bus.lap_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign bus.count     = count_q;
   assign bus.running   = running_q;
   assign bus.wrap      = wrap_q;
   assign bus.lap_valid = !fifo_empty;
   assign bus.lap_full  = fifo_full;
   assign bus.lap_ovf   = ovf_q;
endmodule
